// File: rtl/frame_sync_monitor_if.sv
// Signal bundle between the frame sync source/control side (master) and
// frame_sync_monitor (slave).
interface frame_sync_monitor_if #(
  parameter int PERIOD_WIDTH = 32,
  parameter int COUNT_WIDTH  = 16
);
  logic                    frame_sync_i;
  logic                    clear_i;
  logic                    frame_start_o;
  logic [PERIOD_WIDTH-1:0] frame_period_o;
  logic                    period_valid_o;
  logic [COUNT_WIDTH-1:0]  frame_count_o;
  logic                    locked_o;
  logic                    timeout_o;

  modport master (
    output frame_sync_i, clear_i,
    input  frame_start_o, frame_period_o, period_valid_o,
           frame_count_o, locked_o, timeout_o
  );

  modport slave (
    input  frame_sync_i, clear_i,
    output frame_start_o, frame_period_o, period_valid_o,
           frame_count_o, locked_o, timeout_o
  );
endinterface

// File: rtl/frame_sync_monitor.sv
// Synchronizes and debounces the frame sync level, emits a frame-start strobe,
// measures the frame period and tracks lock / loss-of-signal status.
module frame_sync_monitor #(
  parameter int PERIOD_WIDTH   = 32,
  parameter int COUNT_WIDTH    = 16,
  parameter int SYNC_STAGES    = 2,
  parameter int MIN_HIGH       = 4,
  parameter int TIMEOUT_CYCLES = 100000000
) (
  input logic                 clk_i,
  input logic                 reset_i,
  frame_sync_monitor_if.slave mon
);

  localparam int RUN_WIDTH = (MIN_HIGH > 1) ? $clog2(MIN_HIGH) : 1;
  localparam logic [RUN_WIDTH-1:0]    RUN_LAST    = RUN_WIDTH'(MIN_HIGH - 1);
  localparam logic [PERIOD_WIDTH-1:0] TIMEOUT_VAL = PERIOD_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [PERIOD_WIDTH-1:0] PERIOD_MAX  = '1;

  typedef enum logic [1:0] {
    NO_SIGNAL = 2'd0,
    FIRST     = 2'd1,
    LOCKED    = 2'd2
  } state_e;

  logic [SYNC_STAGES-1:0]  sync_q, sync_d;
  logic                    filt_q, filt_d;
  logic                    filt_last_q, filt_last_d;
  logic [RUN_WIDTH-1:0]    run_q, run_d;
  state_e                  state_q, state_d;
  logic [PERIOD_WIDTH-1:0] counter_q, counter_d;
  logic [PERIOD_WIDTH-1:0] period_q, period_d;
  logic                    valid_q, valid_d;
  logic [COUNT_WIDTH-1:0]  count_q, count_d;
  logic                    locked_q, locked_d;
  logic                    timeout_q, timeout_d;
  logic                    start_q, start_d;
  logic                    sample;
  logic                    start_event;

  // The run counter tracks consecutive samples that disagree with the
  // filtered level; any agreeing sample restarts it.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves a signal unassigned and infers a latch.
    sync_d      = {sync_q[SYNC_STAGES-2:0], mon.frame_sync_i};
    sample      = sync_q[SYNC_STAGES-1];
    filt_d      = filt_q;
    run_d       = '0;
    filt_last_d = filt_q;
    if (sample != filt_q) begin
      if (run_q == RUN_LAST) filt_d = sample;
      else                   run_d  = run_q + RUN_WIDTH'(1);
    end
    start_event = filt_q & ~filt_last_q;
  end

  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    period_d  = period_q;
    valid_d   = valid_q;
    count_d   = count_q;
    timeout_d = timeout_q;
    start_d   = 1'b0;

    if (mon.clear_i) begin
      // Clear beats a coincident start event: the start is simply dropped.
      state_d   = NO_SIGNAL;
      counter_d = '0;
      period_d  = '0;
      valid_d   = 1'b0;
      count_d   = '0;
      timeout_d = 1'b0;
    end else if (start_event) begin
      start_d   = 1'b1;
      count_d   = count_q + COUNT_WIDTH'(1);
      counter_d = PERIOD_WIDTH'(1);
      unique case (state_q)
        NO_SIGNAL: state_d = FIRST;
        FIRST: begin
          state_d  = LOCKED;
          period_d = counter_q;
          valid_d  = 1'b1;
        end
        LOCKED:  period_d = counter_q;
        default: state_d  = NO_SIGNAL;
      endcase
    end else if (state_q == NO_SIGNAL) begin
      counter_d = '0;
    end else if (counter_q == TIMEOUT_VAL) begin
      state_d   = NO_SIGNAL;
      counter_d = '0;
      timeout_d = 1'b1;
      valid_d   = 1'b0;
    end else if (counter_q != PERIOD_MAX) begin
      counter_d = counter_q + PERIOD_WIDTH'(1);
    end

    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sync_q      <= '0;
      filt_q      <= 1'b0;
      filt_last_q <= 1'b0;
      run_q       <= '0;
      state_q     <= NO_SIGNAL;
      counter_q   <= '0;
      period_q    <= '0;
      valid_q     <= 1'b0;
      count_q     <= '0;
      locked_q    <= 1'b0;
      timeout_q   <= 1'b0;
      start_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      sync_q      <= sync_d;
      filt_q      <= filt_d;
      filt_last_q <= filt_last_d;
      run_q       <= run_d;
      state_q     <= state_d;
      counter_q   <= counter_d;
      period_q    <= period_d;
      valid_q     <= valid_d;
      count_q     <= count_d;
      locked_q    <= locked_d;
      timeout_q   <= timeout_d;
      start_q     <= start_d;
    end
  end

  assign mon.frame_start_o  = start_q;
  assign mon.frame_period_o = period_q;
  assign mon.period_valid_o = valid_q;
  assign mon.frame_count_o  = count_q;
  assign mon.locked_o       = locked_q;
  assign mon.timeout_o      = timeout_q;

endmodule
